// File: rtl/shift_exec_stage_pkg.sv
// Shared definitions for the shift execute stage: MIPS shift funct codes
// and the decoded shift-operation type.
package shift_exec_stage_pkg;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;

  typedef enum logic [2:0] {
    OP_SLL,
    OP_SRL,
    OP_SRA,
    OP_SLLV,
    OP_SRLV,
    OP_SRAV,
    OP_ILLEGAL
  } shift_op_e;

  function automatic shift_op_e decode_funct(input logic [5:0] funct);
    shift_op_e op;
    case (funct)
      FN_SLL:  op = OP_SLL;
      FN_SRL:  op = OP_SRL;
      FN_SRA:  op = OP_SRA;
      FN_SLLV: op = OP_SLLV;
      FN_SRLV: op = OP_SRLV;
      FN_SRAV: op = OP_SRAV;
      default: op = OP_ILLEGAL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/shift_exec_stage_shifter.sv
// Combinational barrel shifter: left zero-fill, logical right, or
// arithmetic right replicating the sign bit.
module shifter #(
  parameter int N = 32
) (
  input  logic [N-1:0]         IN,
  input  logic [$clog2(N)-1:0] shamt,
  input  logic                 left,
  input  logic                 logical,
  output logic [N-1:0]         OUT
);

  always_comb begin
    OUT = '0;
    if (left) begin
      OUT = IN << shamt;
    end else if (logical) begin
      OUT = IN >> shamt;
    end else begin
      OUT = $signed(IN) >>> shamt;
    end
  end

endmodule

// File: rtl/shift_exec_stage.sv
// Two-stage MIPS shift execute unit: S1 holds the decoded operation, S2 the
// shifted result, with valid/ready handshakes and a flush.
module shift_exec_stage #(
  parameter  int N  = 32,
  localparam int SA = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [5:0]    in_funct,
  input  logic [N-1:0]  in_rs,
  input  logic [N-1:0]  in_rt,
  input  logic [SA-1:0] in_shamt,
  input  logic [4:0]    in_rd,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_result,
  output logic [4:0]    out_rd,
  output logic          out_illegal
);

  import shift_exec_stage_pkg::*;

  shift_op_e     in_op;
  logic [SA-1:0] in_amt;
  logic          in_left;
  logic          in_logical;
  logic          in_illegal;

  logic          s1_valid;
  logic [SA-1:0] s1_amt;
  logic          s1_left;
  logic          s1_logical;
  logic [N-1:0]  s1_rt;
  logic [4:0]    s1_rd;
  logic          s1_illegal;

  logic          s2_valid;
  logic [N-1:0]  s2_result;
  logic [4:0]    s2_rd;
  logic          s2_illegal;

  logic          s2_load;
  logic          accept;
  logic [N-1:0]  shift_out;

  always_comb begin
    in_op      = decode_funct(in_funct);
    in_amt     = in_shamt;
    in_left    = 1'b0;
    in_logical = 1'b0;
    in_illegal = 1'b0;
    case (in_op)
      OP_SLL:  in_left = 1'b1;
      OP_SRL:  in_logical = 1'b1;
      OP_SRA:  ;
      OP_SLLV: begin
        in_left = 1'b1;
        in_amt  = in_rs[SA-1:0];
      end
      OP_SRLV: begin
        in_logical = 1'b1;
        in_amt     = in_rs[SA-1:0];
      end
      OP_SRAV: in_amt = in_rs[SA-1:0];
      default: begin
        in_illegal = 1'b1;
        in_amt     = '0;
      end
    endcase
  end

  // S2 can take a new value whenever it is empty or being drained; a full S1
  // moves along with it, which is what frees the input slot.
  assign s2_load  = !s2_valid || out_ready;
  assign in_ready = !flush && (!s1_valid || s2_load);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_amt     <= '0;
      s1_left    <= 1'b0;
      s1_logical <= 1'b0;
      s1_rt      <= '0;
      s1_rd      <= '0;
      s1_illegal <= 1'b0;
    end else begin
      if (flush) begin
        s1_valid <= 1'b0;
      end else if (accept) begin
        s1_valid <= 1'b1;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
      if (accept) begin
        s1_amt     <= in_amt;
        s1_left    <= in_left;
        s1_logical <= in_logical;
        s1_rt      <= in_rt;
        s1_rd      <= in_rd;
        s1_illegal <= in_illegal;
      end
    end
  end

  shifter #(.N(N)) u_shifter (
    .IN      (s1_rt),
    .shamt   (s1_amt),
    .left    (s1_left),
    .logical (s1_logical),
    .OUT     (shift_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      s2_result  <= '0;
      s2_rd      <= '0;
      s2_illegal <= 1'b0;
    end else begin
      if (flush) begin
        s2_valid <= 1'b0;
      end else if (s2_load) begin
        s2_valid <= s1_valid;
      end
      if (!flush && s2_load && s1_valid) begin
        s2_result  <= s1_illegal ? '0 : shift_out;
        s2_rd      <= s1_rd;
        s2_illegal <= s1_illegal;
      end
    end
  end

  assign out_valid   = s2_valid;
  assign out_result  = s2_result;
  assign out_rd      = s2_rd;
  assign out_illegal = s2_illegal;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Bench for shift_exec_stage: arithmetic reference model with an occupancy
// scoreboard, plus directed vectors with literal expectations.
module tb_shift_exec_stage;

  import shift_exec_stage_pkg::*;

  localparam int N  = 32;
  localparam int SA = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [5:0]    in_funct;
  logic [N-1:0]  in_rs;
  logic [N-1:0]  in_rt;
  logic [SA-1:0] in_shamt;
  logic [4:0]    in_rd;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_result;
  logic [4:0]    out_rd;
  logic          out_illegal;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  shift_exec_stage #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_funct    (in_funct),
    .in_rs       (in_rs),
    .in_rt       (in_rt),
    .in_shamt    (in_shamt),
    .in_rd       (in_rd),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_rd      (out_rd),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic longint unsigned pow2(input int unsigned a);
    longint unsigned p = 1;
    for (int unsigned i = 0; i < a; i++) p = p * 2;
    return p;
  endfunction

  // Shifts expressed as multiply/divide by powers of two.
  function automatic exp_t model(input logic [5:0] f, input logic [31:0] rs,
                                 input logic [31:0] rt, input logic [4:0] sh,
                                 input logic [4:0] rd);
    exp_t e;
    int unsigned amt;
    longint unsigned t;
    logic [31:0] nrt;
    e.rd  = rd;
    e.ill = 1'b0;
    e.res = '0;
    amt   = (f == FN_SLLV || f == FN_SRLV || f == FN_SRAV) ? rs % 32 : int'(sh);
    nrt   = ~rt;
    if (f == FN_SLL || f == FN_SLLV) begin
      t = longint'(rt) * pow2(amt);
      e.res = t[31:0];
    end else if (f == FN_SRL || f == FN_SRLV) begin
      t = longint'(rt) / pow2(amt);
      e.res = t[31:0];
    end else if (f == FN_SRA || f == FN_SRAV) begin
      t = longint'(rt[31] ? nrt : rt) / pow2(amt);
      e.res = rt[31] ? ~t[31:0] : t[31:0];
    end else begin
      e.ill = 1'b1;
    end
    return e;
  endfunction

  always @(posedge clk) begin
    if (!rst_n || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
      if (in_valid && in_ready) sb.push_back(model(in_funct, in_rs, in_rt, in_shamt, in_rd));
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready_model", {31'b0, in_ready}, {31'b0, !flush && (sb.size() < 2 || out_ready)});
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_output actual_rd=%0d required=no_output", out_rd);
        end else begin
          chk("sb_result", out_result, sb[0].res);
          chk("sb_rd", {27'b0, out_rd}, {27'b0, sb[0].rd});
          chk("sb_illegal", {31'b0, out_illegal}, {31'b0, sb[0].ill});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [4:0] sh, input logic [4:0] rd);
    in_valid = 1'b1;
    in_funct = f;
    in_rs    = rs;
    in_rt    = rt;
    in_shamt = sh;
    in_rd    = rd;
  endtask

  task automatic send(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                      input logic [4:0] sh, input logic [4:0] rd, input bit rnd);
    bit acc;
    int n;
    n = 0;
    drive(f, rs, rt, sh, rd);
    do begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      #1;
      acc = in_ready;
      tick();
      n++;
    end while (!acc && n < 100);
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted");
    end
    in_valid = 1'b0;
  endtask

  logic [5:0] fn_tab [7];

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_funct  = '0;
    in_rs     = '0;
    in_rt     = '0;
    in_shamt  = '0;
    in_rd     = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    fn_tab    = '{FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV, 6'h20};

    chk("model_sra", model(FN_SRA, 32'h0, 32'h80000000, 5'd4, 5'd0).res, 32'hF8000000);
    chk("model_srav_hi_ignored", model(FN_SRAV, 32'hFFFFFFE4, 32'h8000000F, 5'd0, 5'd0).res, 32'hF8000000);

    repeat (2) tick();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_rd", {27'b0, out_rd}, 32'd0);
    chk("rst_out_illegal", {31'b0, out_illegal}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_release_in_ready", {31'b0, in_ready}, 32'd1);

    // SLL by 31
    drive(FN_SLL, 32'h0, 32'h00000001, 5'd31, 5'd5);
    tick();
    in_valid = 1'b0;
    chk("sll31_not_yet", {31'b0, out_valid}, 32'd0);
    tick();
    chk("sll31_valid", {31'b0, out_valid}, 32'd1);
    chk("sll31_result", out_result, 32'h80000000);
    chk("sll31_rd", {27'b0, out_rd}, 32'd5);
    tick();

    // SRA then SRL back-to-back
    drive(FN_SRA, 32'h0, 32'h80000000, 5'd4, 5'd1);
    tick();
    drive(FN_SRL, 32'h0, 32'h80000000, 5'd4, 5'd2);
    tick();
    in_valid = 1'b0;
    chk("sra_result", out_result, 32'hF8000000);
    tick();
    chk("srl_valid", {31'b0, out_valid}, 32'd1);
    chk("srl_result", out_result, 32'h08000000);
    tick();

    // SRLV ignores upper rs bits
    drive(FN_SRLV, 32'hFFFFFFE4, 32'hF0000000, 5'd0, 5'd3);
    tick();
    in_valid = 1'b0;
    tick();
    chk("srlv_result", out_result, 32'h0F000000);
    tick();

    // Backpressure: two held, third waits
    out_ready = 1'b0;
    drive(FN_SLL, 32'h0, 32'd3, 5'd1, 5'd10);
    tick();
    drive(FN_SLL, 32'h0, 32'd3, 5'd2, 5'd11);
    tick();
    drive(FN_SLL, 32'h0, 32'd3, 5'd3, 5'd12);
    chk("full_in_ready", {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
      chk("stall_rd", {27'b0, out_rd}, 32'd10);
      chk("stall_result", out_result, 32'd6);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("drain1_rd", {27'b0, out_rd}, 32'd11);
    chk("drain1_result", out_result, 32'd12);
    tick();
    chk("drain2_rd", {27'b0, out_rd}, 32'd12);
    chk("drain2_result", out_result, 32'd24);
    tick();

    // Illegal funct
    drive(6'h20, 32'h0, 32'h00001234, 5'd3, 5'd7);
    tick();
    in_valid = 1'b0;
    tick();
    chk("illegal_flag", {31'b0, out_illegal}, 32'd1);
    chk("illegal_result", out_result, 32'd0);
    chk("illegal_rd", {27'b0, out_rd}, 32'd7);
    tick();

    // Flush with two in flight and a competing input
    out_ready = 1'b0;
    drive(FN_SLL, 32'h0, 32'd1, 5'd1, 5'd20);
    tick();
    drive(FN_SLL, 32'h0, 32'd1, 5'd2, 5'd21);
    tick();
    drive(FN_SLL, 32'h0, 32'd1, 5'd3, 5'd22);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_clear", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b1;
    tick();
    tick();
    chk("flush_no_stale", {31'b0, out_valid}, 32'd0);

    // Reset mid-stream
    drive(FN_SRL, 32'h0, 32'd8, 5'd1, 5'd23);
    tick();
    drive(FN_SRL, 32'h0, 32'd8, 5'd2, 5'd24);
    tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_async_result", out_result, 32'd0);
    chk("rst_async_rd", {27'b0, out_rd}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("post_rst_valid", {31'b0, out_valid}, 32'd0);

    // Zero shift amount for all six ops (upper rs bits set)
    for (int i = 0; i < 6; i++)
      send(fn_tab[i], 32'hFFFFFFE0, 32'hA5A50F0F, 5'd0, 5'(i + 1), 1'b0);

    // Mixed traffic under random backpressure
    for (int i = 0; i < 40; i++)
      send(fn_tab[$urandom_range(0, 6)], $urandom, $urandom, 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), 1'b1);

    out_ready = 1'b1;
    repeat (4) tick();
    chk("drain_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
